simd_sub_pipe: RTL
==================

Name: simd_sub_pipe

Overview:
- Pipelined packed-SIMD subtractor: c = a - b per lane, with optional signed saturation.
- Lane widths: 4x8, 2x16 or 1x32 bits.
- Complements the combinational packed adder datapath. Adds valid/ready handshakes on both ends and a 2-stage pipeline so it can sit between the operand register stage and writeback.

Parameters:
- DATA_W, 32, total operand width; fixed at 32 (4 byte lanes), other values unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept operand beat
- a  input  32  minuend (packed lanes)
- b  input  32  subtrahend (packed lanes)
- width  input  2  00=4x8, 01=2x16, 10=1x32, 11=treated as 1x32
- saturate  input  1  1=clamp signed overflow, 0=wrap
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- c  output  32  packed difference
- ovf  output  4  per-byte overflow flag; set only on the most significant byte of an overflowing element

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, c=0, ovf=0.
  - Both stage valid bits cleared.
  - in_ready=1 as soon as reset is released.
  - Reset mid-operation discards all in-flight beats. No partial result is ever presented.
- Handshake:
  - A beat transfers on the rising edge where valid&&ready.
  - out_valid, c and ovf hold stable while out_valid=1 and out_ready=0.
  - in_ready may depend combinationally on out_ready. out_valid must not depend on in_valid combinationally.
- Stage 1 (S1), on accept:
  - Compute per-byte a + ~b + carry.
  - Carry into byte 0 is 1. Carry into byte k>0 is the carry-out of byte k-1 when byte k is not an element LSB, else 1.
  - Element LSBs: width 00 = bytes 0,1,2,3; width 01 = bytes 0,2; width 10/11 = byte 0.
  - Register raw difference, per-byte signed overflow, result sign, width and saturate.
  - Signed overflow of an element = (sign a != sign b) && (sign diff != sign a), evaluated at the element MSB byte.
- Stage 2 (S2):
  - saturate=1 and overflow on an element: force the whole element to 0x7F..FF if sign a = 0, else to 0x80..00.
  - Otherwise pass the raw (wrapped) difference.
  - ovf[byte] = overflow at element MSB byte, regardless of saturate. All other ovf bits are 0.
- Pipeline control:
  - s2_ready = !s2_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready.
  - Latency is exactly 2 cycles from accept to out_valid with no stall.
  - Throughput is 1 beat/cycle when out_ready=1.
- Full: both stages valid and out_ready=0 gives in_ready=0. No beat is dropped or duplicated.
- Simultaneous out accept and in accept when full: both transfer in the same cycle and the pipeline advances.
- Empty: out_valid=0. c and ovf hold their last values (don't-care to the bench when out_valid=0).
- Each beat uses its own width/saturate. Mode changes between back-to-back beats must not cross-contaminate.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, release -> out_valid=0, c=0, ovf=0, in_ready=1.
- 8-bit saturate: a=0x80_7F_05_00, b=0x01_FF_03_01, width=00, sat=1 -> c=0x80_7F_02_FF, ovf=4'b1100, out_valid 2 cycles after accept.
- 8-bit wrap: same operands, sat=0 -> c=0x7F_80_02_FF, ovf=4'b1100.
- 16-bit borrow chain: a=0x0000_0100, b=0x0000_0001, width=01, sat=1 -> c=0x0000_00FF, ovf=0. Then a=0x8000_0000, b=0x0001_0000 -> c=0x8000_0000, ovf=4'b1000.
- 32-bit: a=0x7FFFFFFF, b=0xFFFFFFFF, width=10, sat=1 -> c=0x7FFFFFFF, ovf=4'b1000. With width=11 -> identical.
- Backpressure: stream 6 beats with alternating width, hold out_ready=0 for 4 cycles after the 2nd accept.
  - in_ready drops after the 2nd accept.
  - Results match a scoreboard in order; held c/ovf stay stable while stalled.
  - Assert rst_n=0 mid-stream -> out_valid=0 immediately and no stale beat appears afterwards.

Source files
------------

// File: rtl/simd_sub_pipe.sv
// Two-stage packed-SIMD subtractor (4x8 / 2x16 / 1x32 lanes).
// S1 forms the raw byte-chained difference; S2 applies signed saturation.
module simd_sub_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        width,
  input  logic              saturate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] c,
  output logic [3:0]        ovf
);

  function automatic logic [3:0] lsb_of(input logic [1:0] w);
    logic w8;
    w8 = (w == 2'b00);
    return {w8, ~w[1], w8, 1'b1};
  endfunction

  function automatic logic [3:0] msb_of(input logic [1:0] w);
    logic w8;
    w8 = (w == 2'b00);
    return {1'b1, w8, ~w[1], w8};
  endfunction

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_ready;
  logic        s2_ready;
  logic [31:0] s1_diff;
  logic [3:0]  s1_ov;
  logic [3:0]  s1_sign;
  logic [1:0]  s1_width;
  logic        s1_sat;

  logic [3:0]  lsb;
  logic [3:0]  msb;
  logic [8:0]  sum;
  logic        cy;
  logic [31:0] nd;
  logic [3:0]  nov;

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  // a - b = a + ~b + 1, carry restarts at every element LSB byte
  always_comb begin
    lsb = lsb_of(width);
    msb = msb_of(width);
    sum = '0;
    cy  = 1'b1;
    nd  = '0;
    nov = '0;
    for (int k = 0; k < 4; k++) begin
      sum = {1'b0, a[8*k +: 8]}
          + {1'b0, ~b[8*k +: 8]}
          + {8'd0, lsb[k] | cy};
      nd[8*k +: 8] = sum[7:0];
      cy = sum[8];
      nov[k] = msb[k]
             & (a[8*k+7] ^ b[8*k+7])
             & (sum[7] ^ a[8*k+7]);
    end
  end

  logic [3:0]  eov;
  logic [3:0]  esd;
  logic [3:0]  smsb;
  logic [31:0] res;

  // Broadcast each element's MSB-byte overflow/sign to all its bytes
  always_comb begin
    eov  = '0;
    esd  = '0;
    smsb = msb_of(s1_width);
    res  = s1_diff;
    unique case (1'b1)
      s1_width == 2'b00: begin
        eov = s1_ov;
        esd = s1_sign;
      end
      s1_width == 2'b01: begin
        eov = {{2{s1_ov[3]}}, {2{s1_ov[1]}}};
        esd = {{2{s1_sign[3]}}, {2{s1_sign[1]}}};
      end
      default: begin
        eov = {4{s1_ov[3]}};
        esd = {4{s1_sign[3]}};
      end
    endcase
    for (int k = 0; k < 4; k++) begin
      if (s1_sat && eov[k]) begin
        if (esd[k])
          res[8*k +: 8] = smsb[k] ? 8'h7F : 8'hFF;
        else
          res[8*k +: 8] = smsb[k] ? 8'h80 : 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_diff  <= '0;
      s1_ov    <= '0;
      s1_sign  <= '0;
      s1_width <= '0;
      s1_sat   <= 1'b0;
      c        <= '0;
      ovf      <= '0;
    end else begin
      if (s1_ready)
        s1_valid <= in_valid;
      if (in_valid && s1_ready) begin
        s1_diff  <= nd;
        s1_ov    <= nov;
        s1_sign  <= {nd[31], nd[23], nd[15], nd[7]};
        s1_width <= width;
        s1_sat   <= saturate;
      end
      if (s2_ready)
        s2_valid <= s1_valid;
      if (s1_valid && s2_ready) begin
        c   <= res;
        ovf <= s1_ov;
      end
    end
  end

endmodule
